// File: rtl/exe_write_skid_latch.sv
// EXE-to-WB pipeline latch with valid/ready handshake and a 2-entry skid buffer.
// Outputs come only from the OUT register; the SKID register absorbs one entry under WB backpressure.
module exe_write_skid_latch #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned INSTR_W        = 32,
  parameter int unsigned PC_W           = 32,
  parameter bit          ZERO_REG_GUARD = 1'b1
) (
  input  logic               clk_i,
  input  logic               rsn_i,
  input  logic               flush_i,
  input  logic               exe_valid_i,
  output logic               exe_ready_o,
  input  logic [DATA_W-1:0]  exe_int_write_data_i,
  input  logic [ADDR_W-1:0]  exe_write_addr_i,
  input  logic               exe_int_write_enable_i,
  input  logic [INSTR_W-1:0] exe_instruction_i,
  input  logic [PC_W-1:0]    exe_pc_i,
  output logic               write_valid_o,
  input  logic               write_ready_i,
  output logic [DATA_W-1:0]  write_int_write_data_o,
  output logic [ADDR_W-1:0]  write_write_addr_o,
  output logic               write_int_write_enable_o,
  output logic [INSTR_W-1:0] write_instruction_o,
  output logic [PC_W-1:0]    write_pc_o,
  output logic [1:0]         occupancy_o
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  addr;
    logic               we;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  // Encoding is (out_valid, skid_valid).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t in_e;

  logic out_valid;
  logic skid_valid;
  logic guard_hit;
  logic accept;
  logic drain;

  assign out_valid  = (state_q == ONE) || (state_q == FULL);
  assign skid_valid = (state_q == FULL);
  assign guard_hit  = ZERO_REG_GUARD && (exe_write_addr_i == '0);
  assign accept     = exe_valid_i & ~skid_valid;
  assign drain      = out_valid & write_ready_i;

  always_comb begin
    in_e       = '0;
    in_e.data  = exe_int_write_data_i;
    in_e.addr  = exe_write_addr_i;
    in_e.we    = exe_int_write_enable_i & ~guard_hit;
    in_e.instr = exe_instruction_i;
    in_e.pc    = exe_pc_i;
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and payload steering; flush overrides only the valid state.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = in_e;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          out_d = in_e;
        end else if (accept) begin
          skid_d  = in_e;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
    end
  end

  assign exe_ready_o              = ~skid_valid;
  assign write_valid_o            = out_valid;
  assign write_int_write_data_o   = out_q.data;
  assign write_write_addr_o       = out_q.addr;
  assign write_int_write_enable_o = out_q.we & out_valid;
  assign write_instruction_o      = out_q.instr;
  assign write_pc_o               = out_q.pc;
  assign occupancy_o              = 2'(out_valid) + 2'(skid_valid);

endmodule
